// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: encodes mnemonic+field requests into MIPS words and writes them sequentially to instruction memory.
// Optional ILLEGAL_TRAP_EN: ops 14/15 raise a sticky err instead of being written as NOP.
module mips_instr_encoder #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              flush,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state, nxt;
    logic live, acc, trap;
    logic [31:0] enc, word;
    logic [ADDR_W:0] cnt;
    // live keeps in_ready low until the first edge out of reset
    assign full      = cnt == (ADDR_W+1)'(DEPTH);
    assign in_ready  = live && state == IDLE && !full;
    assign acc       = in_valid && in_ready;
    assign mem_we    = state == WRITE;
    assign mem_addr  = cnt[ADDR_W-1:0];
    assign mem_wdata = word;
    assign count     = cnt;
    assign done      = state == DONE;
`ifdef ILLEGAL_TRAP_EN
    logic err_q;
    assign trap = op[3] & op[2] & op[1];
    assign err  = err_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) err_q <= 1'b0;
        else if (state == DONE && restart) err_q <= 1'b0;
        else if (acc && trap) err_q <= 1'b1;
`else
    assign trap = 1'b0;
    assign err  = 1'b0;
`endif
    always_comb begin
        enc = 32'h0;
        case (op)
            4'd0:  enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
            4'd1:  enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
            4'd2:  enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100100};
            4'd3:  enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100101};
            4'd4:  enc = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
            4'd5:  enc = {6'b001000, rs, rt, imm};
            4'd6:  enc = {6'b001100, rs, rt, imm};
            4'd7:  enc = {6'b001101, rs, rt, imm};
            4'd8:  enc = {6'b001010, rs, rt, imm};
            4'd9:  enc = {6'b100011, rs, rt, imm};
            4'd10: enc = {6'b101011, rs, rt, imm};
            4'd11: enc = {6'b000100, rs, rt, imm};
            4'd12: enc = {6'b000010, target};
            default: enc = 32'h0;
        endcase
    end
    always_comb begin
        nxt = state == WRITE ? IDLE :
              state == DONE  ? (restart ? IDLE : DONE) :
              acc            ? (trap ? IDLE : WRITE) :
              flush          ? DONE : IDLE;
    end
    // the write address is the count itself, so no separate pointer is kept
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            live  <= 1'b0;
            cnt   <= '0;
            word  <= '0;
        end else begin
            live  <= 1'b1;
            state <= nxt;
            if (acc) word <= enc;
            if (state == WRITE) cnt <= cnt + 1'b1;
            else if (state == DONE && restart) cnt <= '0;
        end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: randomized and directed checks of mips_instr_encoder against a cycle-level behavioural model.
module tb_mips_instr_encoder;
    logic clk = 0, rst = 1, in_valid = 0, flush = 0, restart = 0;
    logic in_ready, mem_we, full, done, err;
    logic [3:0] op = 0;
    logic [4:0] rs = 0, rt = 0, rd = 0;
    logic [15:0] imm = 0;
    logic [25:0] target = 0;
    logic [5:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0] count;
    logic [31:0] imem [64];
    logic [31:0] exp_mem [64];
    int checks = 0, failures = 0;
    int m_cnt, m_live, m_pend, m_done, m_err;
    logic [31:0] m_word, prior;

    mips_instr_encoder dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .flush(flush), .restart(restart),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .full(full),
        .done(done), .err(err));

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_we) imem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_enc(int o, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                            logic [15:0] i, logic [25:0] g);
        int fn [5] = '{32, 34, 36, 37, 42};
        int opc [7] = '{8, 12, 13, 10, 35, 43, 4};
        if (o < 5) return (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(fn[o]);
        if (o < 12) return (32'(opc[o-5]) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(i);
        if (o == 12) return (32'd2 << 26) | 32'(g);
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_live = 0; m_pend = 0; m_done = 0; m_err = 0;
    endtask

    task automatic tick();
        int rdy, ill;
        rdy = m_live && !m_pend && !m_done && m_cnt < 64;
        check("in_ready", in_ready, rdy);
        check("mem_we", mem_we, m_pend);
        check("count", count, m_cnt);
        check("full", full, m_cnt == 64);
        check("done", done, m_done);
        check("err", err, m_err);
        if (m_pend) begin
            check("mem_addr", mem_addr, m_cnt % 64);
            check("mem_wdata", mem_wdata, m_word);
        end
        ill = op >= 14;
`ifndef ILLEGAL_TRAP_EN
        ill = 0;
`endif
        if (m_pend) begin
            exp_mem[m_cnt % 64] = m_word;
            m_cnt++;
            m_pend = 0;
        end else if (m_done) begin
            if (restart) begin m_done = 0; m_cnt = 0; m_err = 0; end
        end else if (rdy && in_valid) begin
            if (ill) m_err = 1;
            else begin m_pend = 1; m_word = ref_enc(int'(op), rs, rt, rd, imm, target); end
        end else if (flush) m_done = 1;
        m_live = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int o, input int s, input int t, input int d, input int i, input int g);
        op = 4'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(i); target = 26'(g);
        in_valid = 1; tick(); in_valid = 0; tick();
    endtask

    task automatic pulse_flush(); flush = 1; tick(); flush = 0; endtask
    task automatic pulse_restart(); restart = 1; tick(); restart = 0; endtask

    initial begin
        for (int i = 0; i < 64; i++) begin imem[i] = 32'hDEADBEEF; exp_mem[i] = 32'hDEADBEEF; end
        model_reset();
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        #9 rst = 0;
        tick();
        req(0, 1, 2, 3, 0, 0);
        check("add_word", imem[0], 32'h0022_1820);
        check("add_count", count, 1);
        pulse_flush();
        check("flush_done", done, 1);
        pulse_flush();
        pulse_restart();
        check("restart_count", count, 0);
        req(9, 29, 8, 0, 16'h0004, 0);
        req(11, 1, 2, 0, 16'hFFFF, 0);
        req(12, 0, 0, 0, 0, 26'h10);
        check("lw_word", imem[0], 32'h8FA8_0004);
        check("beq_word", imem[1], 32'h1022_FFFF);
        check("j_word", imem[2], 32'h0800_0010);
        op = 4'd3; in_valid = 1; flush = 1; tick();
        in_valid = 0; flush = 0; tick();
        check("valid_flush_done", done, 0);
        check("valid_flush_word", imem[3], ref_enc(3, rs, rt, rd, imm, target));
        req(14, 5, 6, 7, 16'h1234, 0);
`ifdef ILLEGAL_TRAP_EN
        check("ill_count", count, 4);
        check("ill_err", err, 1);
`else
        check("ill_word", imem[4], 32'h0);
        check("ill_err", err, 0);
`endif
        for (int n = 0; n < 700; n++) begin
            op = 4'($urandom_range(0, 15)); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            imm = 16'($urandom); target = 26'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 39) == 0;
            restart = $urandom_range(0, 3) == 0;
            tick();
        end
        in_valid = 0; flush = 0; restart = 0;
        tick();
        pulse_flush();
        pulse_restart();
        for (int n = 0; n < 64; n++)
            req($urandom_range(0, 13), $urandom, $urandom, $urandom, $urandom, $urandom);
        check("full_flag", full, 1);
        check("full_ready", in_ready, 0);
        check("full_count", count, 64);
        req(0, 1, 1, 1, 0, 0);
        check("held_count", count, 64);
        for (int i = 0; i < 64; i++) check($sformatf("mem%0d", i), imem[i], exp_mem[i]);
        pulse_flush();
        check("full_flush_done", done, 1);
        pulse_restart();
        check("restart_ready", in_ready, 1);
        check("restart_count2", count, 0);
        prior = imem[0];
        op = 4'd10; rs = 5'd4; rt = 5'd9; imm = 16'h0010; in_valid = 1; tick();
        in_valid = 0;
        check("sw_we", mem_we, 1);
        rst = 1;
        #1;
        check("rst_we_drop", mem_we, 0);
        check("rst_count_mid", count, 0);
        check("rst_ready_mid", in_ready, 0);
        rst = 0;
        model_reset();
        tick();
        tick();
        check("rst_mem_kept", imem[0], prior);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
